// File: rtl/psum_pkg.sv
// Shared types and default widths for the partial-sum accumulator.
package psum_pkg;

    localparam int PSUM_DATA_WIDTH = 32;
    localparam int PSUM_ADDR_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2
    } psum_state_t;

    // Control part of an S1/S2 pipeline entry; address and data are kept
    // beside it because their widths follow the module parameters.
    typedef struct packed {
        logic vld;
        logic first;
    } pipe_entry_t;

endpackage

// File: rtl/psum_adder.sv
// Partial-sum adder: wraps by default, saturates when PSUM_SAT_EN is defined.
// Latency: combinational.
// Backpressure: none.
module psum_adder
    import psum_pkg::*;
#(
    parameter int DATA_WIDTH = PSUM_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] operand,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [DATA_WIDTH-1:0] sum
);

    logic [DATA_WIDTH-1:0] raw;

    assign raw = operand + data;

`ifdef PSUM_SAT_EN
    logic ovf;

    // Overflow only when both operands share a sign the result lost.
    assign ovf = (operand[DATA_WIDTH-1] == data[DATA_WIDTH-1]) &&
                 (raw[DATA_WIDTH-1] != operand[DATA_WIDTH-1]);

    always_comb begin
        sum = raw;
        if (ovf) begin
            sum = operand[DATA_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                        : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
    end
`else
    assign sum = raw;
`endif

endmodule

// File: rtl/psum_accum.sv
// Read-modify-write psum accumulator with drain streamer (optional PSUM_SAT_EN saturation).
// Latency: 2 cycles acceptance -> buf_wren; drain words appear 1 cycle after each read.
// Backpressure: in_ready low only while draining; the drain stream has no backpressure.
module psum_accum
    import psum_pkg::*;
#(
    parameter int DATA_WIDTH = PSUM_DATA_WIDTH,
    parameter int ADDR_WIDTH = PSUM_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_first,
    output logic [ADDR_WIDTH-1:0] buf_raddr,
    input  logic [DATA_WIDTH-1:0] buf_rdat,
    output logic [ADDR_WIDTH-1:0] buf_waddr,
    output logic [DATA_WIDTH-1:0] buf_wdat,
    output logic                  buf_wren,
    input  logic                  drain_start,
    input  logic [ADDR_WIDTH-1:0] drain_base,
    input  logic [ADDR_WIDTH-1:0] drain_len,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy
);

    localparam logic [ADDR_WIDTH-1:0] A_ONE = ADDR_WIDTH'(1);

    psum_state_t           state;
    psum_state_t           state_nxt;
    pipe_entry_t           s1;
    logic [ADDR_WIDTH-1:0] s1_addr;
    logic [DATA_WIDTH-1:0] s1_data;
    logic                  hold_vld;
    logic [ADDR_WIDTH-1:0] hold_addr;
    logic [DATA_WIDTH-1:0] hold_dat;
    logic [ADDR_WIDTH-1:0] drn_base;
    logic [ADDR_WIDTH-1:0] drn_len;
    logic [ADDR_WIDTH-1:0] drn_cnt;
    logic                  drain_rd;
    logic                  xfer;
    logic [DATA_WIDTH-1:0] operand;
    logic [DATA_WIDTH-1:0] sum;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    state_nxt = ST_ACCUM;
                end else if (drain_start && (drain_len != '0)) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_ACCUM: begin
                if (!in_valid && !s1.vld && !buf_wren) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (out_last) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Read port is shared: drain reads while draining, S0 lookups otherwise.
    always_comb begin
        in_ready  = 1'b0;
        drain_rd  = 1'b0;
        buf_raddr = '0;
        case (state)
            ST_IDLE, ST_ACCUM: in_ready = rst;
            ST_DRAIN:          drain_rd = (drn_cnt != drn_len);
            default:           in_ready = 1'b0;
        endcase
        if (drain_rd) begin
            buf_raddr = drn_base + drn_cnt;
        end else if (in_valid && in_ready) begin
            buf_raddr = in_addr;
        end
    end

    assign xfer     = in_valid && in_ready;
    assign busy     = (state != ST_IDLE) || s1.vld || buf_wren;
    assign out_data = out_valid ? buf_rdat : '0;

    // Newest write wins: the one still in S2, then the one that just landed
    // in the buffer after S1's read was already issued.
    always_comb begin
        if (s1.first) begin
            operand = '0;
        end else if (buf_wren && (buf_waddr == s1_addr)) begin
            operand = buf_wdat;
        end else if (hold_vld && (hold_addr == s1_addr)) begin
            operand = hold_dat;
        end else begin
            operand = buf_rdat;
        end
    end

    psum_adder #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_adder (
        .operand(operand),
        .data   (s1_data),
        .sum    (sum)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1        <= '0;
            s1_addr   <= '0;
            s1_data   <= '0;
            buf_wren  <= 1'b0;
            buf_waddr <= '0;
            buf_wdat  <= '0;
            hold_vld  <= 1'b0;
            hold_addr <= '0;
            hold_dat  <= '0;
        end else begin
            s1.vld <= xfer;
            if (xfer) begin
                s1.first <= in_first;
                s1_addr  <= in_addr;
                s1_data  <= in_data;
            end
            buf_wren <= s1.vld;
            if (s1.vld) begin
                buf_waddr <= s1_addr;
                buf_wdat  <= sum;
            end
            hold_vld  <= buf_wren;
            hold_addr <= buf_waddr;
            hold_dat  <= buf_wdat;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drn_base  <= '0;
            drn_len   <= '0;
            drn_cnt   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            if ((state == ST_IDLE) && (state_nxt == ST_DRAIN)) begin
                drn_base <= drain_base;
                drn_len  <= drain_len;
                drn_cnt  <= '0;
            end else if (drain_rd) begin
                drn_cnt <= drn_cnt + A_ONE;
            end
            out_valid <= drain_rd;
            out_last  <= drain_rd && ((drn_cnt + A_ONE) == drn_len);
        end
    end

endmodule

// File: tb/tb_psum_accum.sv
// Bench for psum_accum: buffer RAM model, order-based psum reference model, scenario tasks.
module tb_psum_accum;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_addr;
    logic [31:0] in_data;
    logic        in_first;
    logic [31:0] buf_raddr;
    logic [31:0] buf_rdat = '0;
    logic [31:0] buf_waddr;
    logic [31:0] buf_wdat;
    logic        buf_wren;
    logic        drain_start;
    logic [31:0] drain_base;
    logic [31:0] drain_len;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;

    logic [31:0] ram [0:255] = '{default: '0};
    logic [31:0] ref_mem [logic [31:0]];
    wr_t         wr_log[$];
    wr_t         exp_q[$];
    logic [31:0] raddr_q[$];
    logic [31:0] out_q[$];
    logic        last_q[$];
    bit          rdy_hi;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    psum_accum dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .in_first   (in_first),
        .buf_raddr  (buf_raddr),
        .buf_rdat   (buf_rdat),
        .buf_waddr  (buf_waddr),
        .buf_wdat   (buf_wdat),
        .buf_wren   (buf_wren),
        .drain_start(drain_start),
        .drain_base (drain_base),
        .drain_len  (drain_len),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Synchronous buffer, 1-cycle read, read-before-write (low byte of address).
    always @(posedge clk) begin
        buf_rdat <= ram[buf_raddr[7:0]];
        if (buf_wren) ram[buf_waddr[7:0]] <= buf_wdat;
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (buf_wren) begin
            wr_t e;
            e.addr = buf_waddr;
            e.data = buf_wdat;
            e.cyc  = cyc;
            wr_log.push_back(e);
        end
    end

    function automatic logic [31:0] madd(input logic [31:0] x, input logic [31:0] y);
        longint s;
        s = longint'($signed(x)) + longint'($signed(y));
`ifdef PSUM_SAT_EN
        if (s > 64'sd2147483647) s = 64'sd2147483647;
        if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
        return s[31:0];
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    task automatic send(input logic [31:0] a, input logic [31:0] d, input logic f, input bit track);
        wr_t e;
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        in_first = f;
        if (in_ready && track) begin
            ref_mem[a] = f ? d : madd(ref_rd(a), d);
            e.addr = a;
            e.data = ref_mem[a];
            e.cyc  = cyc + 2;
            exp_q.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_first = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_drain(input logic [31:0] base, input logic [31:0] len);
        bit got_last;
        raddr_q.delete();
        out_q.delete();
        last_q.delete();
        rdy_hi      = 1'b0;
        got_last    = 1'b0;
        drain_start = 1'b1;
        drain_base  = base;
        drain_len   = len;
        @(negedge clk);
        drain_start = 1'b0;
        for (int c = 0; c < int'(len) + 8 && !got_last; c++) begin
            if (c < int'(len)) raddr_q.push_back(buf_raddr);
            if (in_ready) rdy_hi = 1'b1;
            if (out_valid) begin
                out_q.push_back(out_data);
                last_q.push_back(out_last);
                got_last = out_last;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        logic [31:0] obs [9];
        string       nm  [9];
        rst = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0; in_first = 1'b0;
        drain_start = 1'b0; drain_base = '0; drain_len = '0;
        repeat (3) @(negedge clk);
        obs[0] = 32'(in_ready);  nm[0] = "reset_in_ready";
        obs[1] = 32'(busy);      nm[1] = "reset_busy";
        obs[2] = 32'(buf_wren);  nm[2] = "reset_buf_wren";
        obs[3] = 32'(out_valid); nm[3] = "reset_out_valid";
        obs[4] = 32'(out_last);  nm[4] = "reset_out_last";
        obs[5] = buf_raddr;      nm[5] = "reset_buf_raddr";
        obs[6] = buf_waddr;      nm[6] = "reset_buf_waddr";
        obs[7] = buf_wdat;       nm[7] = "reset_buf_wdat";
        obs[8] = out_data;       nm[8] = "reset_out_data";
        for (int i = 0; i < 9; i++) begin
            n_chk++;
            if (obs[i] !== 32'h0) begin
                n_fail++;
                $display("FAIL %s: got %h expected 0", nm[i], obs[i]);
            end
        end
        rst = 1'b1;
        #1;
        n_chk++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b expected 1", in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_spaced_accum;
        bit ok;
        send(32'h10, 32'd5, 1'b1, 1'b1);
        idle(2);
        send(32'h10, 32'd7, 1'b0, 1'b1);
        wait_idle(ok);
        n_chk++;
        if (!ok) begin n_fail++; $display("FAIL spaced_idle: busy stuck high, expected low"); end
        do_drain(32'h10, 32'd1);
        n_chk++;
        if (out_q.size() != 1 || out_q[0] !== 32'd12 || out_q[0] !== ref_rd(32'h10)) begin
            n_fail++;
            $display("FAIL spaced_data: got %0d words first %0d expected 1 word 12", out_q.size(), out_q.size() ? out_q[0] : 32'h0);
        end
        n_chk++;
        if (last_q.size() != 1 || last_q[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL spaced_last: out_last missing on single drained word");
        end
        n_chk++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL spaced_back_idle: in_ready %b expected 1", in_ready); end
    endtask

    task automatic test_back_to_back;
        bit ok;
        wr_log.delete();
        exp_q.delete();
        send(32'h3, 32'd1, 1'b1, 1'b1);
        send(32'h3, 32'd2, 1'b0, 1'b1);
        send(32'h3, 32'd3, 1'b0, 1'b1);
        send(32'h3, 32'd4, 1'b0, 1'b1);
        wait_idle(ok);
        n_chk++;
        if (!ok || wr_log.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL b2b_write_count: got %0d writes expected %0d", wr_log.size(), exp_q.size());
        end else begin
            for (int i = 0; i < wr_log.size(); i++) begin
                n_chk++;
                if (wr_log[i].addr !== exp_q[i].addr || wr_log[i].data !== exp_q[i].data || wr_log[i].cyc != exp_q[i].cyc) begin
                    n_fail++;
                    $display("FAIL b2b_write%0d: got a=%h d=%0d c=%0d expected a=%h d=%0d c=%0d", i,
                             wr_log[i].addr, wr_log[i].data, wr_log[i].cyc, exp_q[i].addr, exp_q[i].data, exp_q[i].cyc);
                end
            end
        end
        n_chk++;
        if (buf_wdat !== 32'd10) begin n_fail++; $display("FAIL b2b_final_wdat: got %0d expected 10", buf_wdat); end
    endtask

    task automatic test_alternate;
        bit ok;
        send(32'h0, 32'd1, 1'b1, 1'b1);
        send(32'h1, 32'd1, 1'b1, 1'b1);
        send(32'h0, 32'd1, 1'b0, 1'b1);
        send(32'h1, 32'd1, 1'b0, 1'b1);
        wait_idle(ok);
        do_drain(32'h0, 32'd2);
        n_chk++;
        if (!ok || out_q.size() != 2 || out_q[0] !== 32'd2 || out_q[1] !== 32'd2) begin
            n_fail++;
            $display("FAIL alternate_data: got %0d words [%0d %0d] expected [2 2]", out_q.size(),
                     out_q.size() > 0 ? out_q[0] : 32'h0, out_q.size() > 1 ? out_q[1] : 32'h0);
        end
    endtask

    task automatic test_overflow;
        bit          ok;
        logic [31:0] exp_pos;
        logic [31:0] exp_neg;
`ifdef PSUM_SAT_EN
        exp_pos = 32'h7FFFFFFF;
        exp_neg = 32'h80000000;
`else
        exp_pos = 32'h80000000;
        exp_neg = 32'h7FFFFFFF;
`endif
        send(32'h20, 32'h7FFFFFFF, 1'b1, 1'b1);
        send(32'h20, 32'h00000001, 1'b0, 1'b1);
        send(32'h21, 32'h80000000, 1'b1, 1'b1);
        send(32'h21, 32'hFFFFFFFF, 1'b0, 1'b1);
        wait_idle(ok);
        do_drain(32'h20, 32'd2);
        n_chk++;
        if (!ok || out_q.size() != 2 || out_q[0] !== exp_pos || out_q[0] !== ref_rd(32'h20)) begin
            n_fail++;
            $display("FAIL overflow_pos: got %h expected %h", out_q.size() > 0 ? out_q[0] : 32'h0, exp_pos);
        end
        n_chk++;
        if (out_q.size() != 2 || out_q[1] !== exp_neg || out_q[1] !== ref_rd(32'h21)) begin
            n_fail++;
            $display("FAIL overflow_neg: got %h expected %h", out_q.size() > 1 ? out_q[1] : 32'h0, exp_neg);
        end
    endtask

    task automatic test_drain_wrap;
        bit          ok;
        logic [31:0] exp_a [3];
        exp_a[0] = 32'hFFFFFFFE;
        exp_a[1] = 32'hFFFFFFFF;
        exp_a[2] = 32'h0;
        send(exp_a[0], 32'hA1, 1'b1, 1'b1);
        send(exp_a[1], 32'hB2, 1'b1, 1'b1);
        send(exp_a[2], 32'hC3, 1'b1, 1'b1);
        wait_idle(ok);
        wr_log.delete();
        do_drain(32'hFFFFFFFE, 32'd3);
        n_chk++;
        if (!ok || raddr_q.size() != 3 || out_q.size() != 3) begin
            n_fail++;
            $display("FAIL wrap_count: got %0d reads %0d words expected 3 and 3", raddr_q.size(), out_q.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_chk++;
                if (raddr_q[k] !== exp_a[k] || out_q[k] !== ref_rd(exp_a[k]) || last_q[k] !== (k == 2)) begin
                    n_fail++;
                    $display("FAIL wrap_word%0d: got a=%h d=%h last=%b expected a=%h d=%h last=%b", k,
                             raddr_q[k], out_q[k], last_q[k], exp_a[k], ref_rd(exp_a[k]), k == 2);
                end
            end
        end
        n_chk++;
        if (rdy_hi) begin n_fail++; $display("FAIL wrap_ready: in_ready went 1 during drain, expected 0"); end
        n_chk++;
        if (wr_log.size() != 0) begin n_fail++; $display("FAIL wrap_no_write: got %0d writes expected 0", wr_log.size()); end
        n_chk++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_return_idle: in_ready %b busy %b expected 1 0", in_ready, busy);
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        wait_idle(ok);
        wr_log.delete();
        send(32'h30, 32'd9, 1'b1, 1'b0);
        rst = 1'b0;
        #1;
        n_chk++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || buf_wren !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_during: busy %b in_ready %b wren %b expected 0 0 0", busy, in_ready, buf_wren);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_chk++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_release: in_ready %b busy %b expected 1 0", in_ready, busy);
        end
        @(negedge clk);
        idle(3);
        n_chk++;
        if (wr_log.size() != 0) begin n_fail++; $display("FAIL midrst_no_write: got %0d writes expected 0", wr_log.size()); end
        do_drain(32'h30, 32'd1);
        n_chk++;
        if (out_q.size() != 1 || out_q[0] !== ref_rd(32'h30)) begin
            n_fail++;
            $display("FAIL midrst_buffer: got %h expected %h", out_q.size() ? out_q[0] : 32'hX, ref_rd(32'h30));
        end
    endtask

    task automatic test_random;
        bit          ok;
        logic [31:0] a;
        logic [31:0] d;
        logic        f;
        wr_log.delete();
        exp_q.delete();
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 9) < 7) begin
                a = 32'h40 + 32'($urandom_range(0, 3));
                d = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 100));
                f = !ref_mem.exists(a) || ($urandom_range(0, 3) == 0);
                send(a, d, f, 1'b1);
            end else begin
                idle(1);
            end
        end
        wait_idle(ok);
        n_chk++;
        if (!ok || wr_log.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL rand_write_count: got %0d writes expected %0d", wr_log.size(), exp_q.size());
        end else begin
            for (int i = 0; i < wr_log.size(); i++) begin
                n_chk++;
                if (wr_log[i].addr !== exp_q[i].addr || wr_log[i].data !== exp_q[i].data || wr_log[i].cyc != exp_q[i].cyc) begin
                    n_fail++;
                    $display("FAIL rand_write%0d: got a=%h d=%h c=%0d expected a=%h d=%h c=%0d", i,
                             wr_log[i].addr, wr_log[i].data, wr_log[i].cyc, exp_q[i].addr, exp_q[i].data, exp_q[i].cyc);
                end
            end
        end
        do_drain(32'h40, 32'd4);
        n_chk++;
        if (out_q.size() != 4) begin
            n_fail++;
            $display("FAIL rand_drain_count: got %0d words expected 4", out_q.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_chk++;
                if (out_q[k] !== ref_rd(32'h40 + 32'(k))) begin
                    n_fail++;
                    $display("FAIL rand_drain%0d: got %h expected %h", k, out_q[k], ref_rd(32'h40 + 32'(k)));
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_spaced_accum();
        test_back_to_back();
        test_alternate();
        test_overflow();
        test_drain_wrap();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
